sram_axi_bridge: RTL and testbench
==================================

// Module: sram_axi_bridge
// PURPOSE
//  Sits downstream of the instruction cache and the data cache. Accepts two sram-like masters
//  (inst, data) and drives one AXI4 master port: AR/R for reads, AW/W/B for writes.
//  Single-beat transfers only (cache line = 1 word). At most one read and one write in flight.
//  A data-side write may overlap an inst-side read.
// PARAMETERS
//  INST_ID  0  AXI ID used for inst reads (arid)
//  DATA_ID  1  AXI ID used for data reads/writes (arid/awid)
// PORTS
//  clk                    in   1   clock, all logic on posedge
//  rst                    in   1   synchronous, active-high reset
//  {inst,data}_req        in   1   request valid, held until addr_ok
//  {inst,data}_wr         in   1   1=write, 0=read (inst_wr always 0 in practice; inst writes ignored)
//  {inst,data}_size       in   2   0=byte 1=half 2=word
//  {inst,data}_addr       in   32  byte address
//  {inst,data}_wdata      in   32  write data, lane-aligned
//  {inst,data}_rdata      out  32  read data, valid with data_ok
//  {inst,data}_addr_ok    out  1   request accepted this cycle
//  {inst,data}_data_ok    out  1   read data returned / write response received this cycle
//  arid/awid              out  4   transaction ID
//  araddr/awaddr          out  32  captured request address
//  arlen/awlen            out  8   always 0
//  arsize/awsize          out  3   {1'b0,size}
//  arburst/awburst        out  2   always 2'b01 (INCR)
//  arvalid/awvalid/wvalid out  1   channel valid
//  arready/awready/wready in   1   channel ready
//  rid/bid                in   4   response ID
//  rdata                  in   32  read data
//  rresp/bresp            in   2   response code
//  rlast                  in   1   last beat (always 1, not checked)
//  rvalid/bvalid          in   1   response valid
//  rready/bready          out  1   response ready
//  wdata/wstrb            out  32/4  write data / byte strobes
//  wlast                  out  1   always 1
// BEHAVIOUR
//  Read FSM: R_IDLE -> R_AR on accept; R_AR -> R_R on arvalid&&arready; R_R -> R_IDLE on rvalid&&rready.
//  Write FSM: W_IDLE -> W_AW on accept; leave W_AW once both AW and W handshakes are done,
//   in either order or together; tracked by aw_done/w_done flags. W_AW -> W_B; W_B -> W_IDLE on bvalid&&bready.
//  Accept (addr_ok):
//   - combinational; read needs R_IDLE, write needs W_IDLE.
//   - Data has priority over inst when both want R_IDLE in the same cycle.
//   - Data master has at most one outstanding access: no new data accept until its data_ok.
//  RAW hazard: a read is not accepted while the write FSM is not W_IDLE and read addr[31:2] == awaddr[31:2].
//  Accepted request's addr/size/wdata/source are registered.
//  AXI outputs driven from registers:
//   - arvalid=1 in R_AR; awvalid=1 in W_AW && !aw_done; wvalid=1 in W_AW && !w_done.
//   - rready=1 in R_R; bready=1 in W_B.
//  wstrb from captured size/addr:
//   - size0: 4'b0001<<addr[1:0]
//   - size1: 4'b0011<<{addr[1],1'b0}
//   - size2: 4'b1111
//  data_ok:
//   - inst_data_ok = rvalid&&rready&&rid==INST_ID
//   - data_data_ok = (rvalid&&rready&&rid==DATA_ID) || (bvalid&&bready)
//   - {inst,data}_rdata = rdata.
//  Latency, zero-wait slave: addr_ok cycle 0, arvalid cycle 1, earliest data_ok cycle 2.
//  Reset:
//   - both FSMs idle; all valids/readies, addr_ok, data_ok = 0; captured regs = 0.
//   - In-flight transactions are dropped; the AXI slave shares rst.
// CONFIGURATION
//  SRAM_AXI_ERR_EN defined:
//   - adds output bus_err (1b), reset 0.
//   - Set sticky on rvalid&&rready&&rresp!=0 or bvalid&&bready&&bresp!=0; cleared only by rst.
//  SRAM_AXI_ERR_EN undefined: no bus_err port; resp fields ignored.
// TESTING
//  1. inst read 0xBFC00000, arready=1, rvalid 1 cycle later, rdata=0x3C1D0001
//     -> arsize=2, arid=0; inst_data_ok with rdata=0x3C1D0001 at cycle 2.
//  2. inst and data reads same cycle -> data granted first (arid=1); inst addr_ok after data's R completes.
//  3. data sb addr 0x80000003 wdata=0xAA000000
//     -> wstrb=4'b1000, awsize=0; awready before wready and reversed order both complete;
//        data_data_ok on bvalid.
//  4. data write 0x80001000 in W_B, then data read 0x80001000
//     -> read blocked until bvalid; read 0x80001004 by inst proceeds concurrently.
//  5. rst asserted in R_R -> next cycle arvalid=rready=0, addr_ok/data_ok=0, new request accepted after rst drops.
//  6. SRAM_AXI_ERR_EN: bresp=2'b10 -> bus_err=1 and stays 1 through later OKAY responses until rst.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Bridges the inst/data sram-like masters onto one single-beat AXI4 master (one read + one write in flight).
// Optional sticky bus_err output is enabled with `define SRAM_AXI_ERR_EN.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
`ifdef SRAM_AXI_ERR_EN
  output logic        bus_err,
`endif
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t r_state;
  w_state_t w_state;
  logic     aw_done;
  logic     w_done;
  logic     data_busy;

  logic w_busy;
  logic data_raw;
  logic inst_raw;
  logic data_rd_acc;
  logic data_wr_acc;
  logic inst_rd_acc;
  logic r_fire;
  logic b_fire;
  logic aw_fire;
  logic w_fire;
  logic aw_all;
  logic w_all;
  logic [3:0] strb_next;

  // A read must not overtake a pending write to the same word.
  assign w_busy   = (w_state != W_IDLE);
  assign data_raw = w_busy && (data_addr[31:2] == awaddr[31:2]);
  assign inst_raw = w_busy && (inst_addr[31:2] == awaddr[31:2]);

  assign data_rd_acc = !rst && data_req && !data_wr && !data_busy &&
                       (r_state == R_IDLE) && !data_raw;
  assign data_wr_acc = !rst && data_req && data_wr && !data_busy && (w_state == W_IDLE);
  assign inst_rd_acc = !rst && inst_req && (r_state == R_IDLE) && !inst_raw && !data_rd_acc;

  assign data_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_addr_ok = inst_rd_acc;

  assign r_fire  = rvalid && rready;
  assign b_fire  = bvalid && bready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign aw_all  = aw_done || aw_fire;
  assign w_all   = w_done || w_fire;

  assign inst_data_ok = !rst && r_fire && (rid == INST_ID);
  assign data_data_ok = !rst && ((r_fire && (rid == DATA_ID)) || b_fire);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awid    = DATA_ID;
  assign wlast   = 1'b1;

  always_comb begin
    strb_next = 4'b1111;
    case (data_size)
      2'd0:    strb_next = 4'b0001 << data_addr[1:0];
      2'd1:    strb_next = 4'b0011 << {data_addr[1], 1'b0};
      default: strb_next = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arid    <= 4'd0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_acc) begin
            arid    <= DATA_ID;
            araddr  <= data_addr;
            arsize  <= {1'b0, data_size};
            arvalid <= 1'b1;
            r_state <= R_AR;
          end else if (inst_rd_acc) begin
            arid    <= INST_ID;
            araddr  <= inst_addr;
            arsize  <= {1'b0, inst_size};
            arvalid <= 1'b1;
            r_state <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            awaddr  <= data_addr;
            awsize  <= {1'b0, data_size};
            wdata   <= data_wdata;
            wstrb   <= strb_next;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_AW;
          end
        end
        W_AW: begin
          // AW and W may complete in either order or together.
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_all && w_all) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            w_state <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_busy <= 1'b0;
    end else if (data_addr_ok) begin
      data_busy <= 1'b1;
    end else if (data_data_ok) begin
      data_busy <= 1'b0;
    end
  end

`ifdef SRAM_AXI_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((r_fire && (rresp != 2'b00)) || (b_fire && (bresp != 2'b00))) begin
      bus_err <= 1'b1;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{inst_wr, inst_wdata, rlast, bid};
`else
  logic unused_sig;
  assign unused_sig = ^{inst_wr, inst_wdata, rlast, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; define SRAM_AXI_ERR_EN to also exercise bus_err.
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
`ifdef SRAM_AXI_ERR_EN
  logic        bus_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
`ifdef SRAM_AXI_ERR_EN
    .bus_err(bus_err),
`endif
    .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait data write with AW and W accepted together; leaves the bridge idle.
  task automatic data_write(input logic [31:0] a, input logic [1:0] resp);
    data_req = 1; data_wr = 1; data_size = 2; data_addr = a; data_wdata = 32'h5A5A5A5A;
    #2; chk("dw_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1; wready = 1;
    tick(); awready = 0; wready = 0; bvalid = 1; bid = 4'd1; bresp = resp;
    #2; chk("dw_data_ok", {31'd0, data_data_ok}, 1);
    tick(); bvalid = 0; bresp = 2'b00;
  endtask

  initial begin
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state
    tick(); inst_req = 1; inst_addr = 32'h100;
    #2; chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_awvalid_wvalid", {30'd0, awvalid, wvalid}, 0);
    chk("rst_readies", {30'd0, rready, bready}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    tick(); inst_req = 0;

    // 1: inst read, zero-wait slave
    rst = 0; inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2;
    #2; chk("t1_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    #2; chk("t1_arvalid", {31'd0, arvalid}, 1);
    chk("t1_araddr", araddr, 32'hBFC00000);
    chk("t1_arsize", {29'd0, arsize}, 2);
    chk("t1_arid", {28'd0, arid}, 0);
    chk("t1_arlen_arburst", {22'd0, arlen, arburst}, {22'd0, 8'd0, 2'b01});
    tick(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h3C1D0001;
    #2; chk("t1_rready", {31'd0, rready}, 1);
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D0001);
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 0);
    tick(); rvalid = 0;
    #2; chk("t1_rready_low", {31'd0, rready}, 0);

    // 2: simultaneous inst and data reads, data wins
    inst_req = 1; inst_addr = 32'hBFC00010;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000020;
    #2; chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("t2_inst_blocked", {31'd0, inst_addr_ok}, 0);
    tick(); data_req = 0; arready = 1;
    #2; chk("t2_arid_data", {28'd0, arid}, 1);
    chk("t2_araddr_data", araddr, 32'h80000020);
    chk("t2_inst_wait_ar", {31'd0, inst_addr_ok}, 0);
    tick(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h12345678;
    #2; chk("t2_data_data_ok", {31'd0, data_data_ok}, 1);
    chk("t2_data_rdata", data_rdata, 32'h12345678);
    chk("t2_no_inst_data_ok", {31'd0, inst_data_ok}, 0);
    chk("t2_inst_wait_r", {31'd0, inst_addr_ok}, 0);
    tick(); rvalid = 0;
    #2; chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    #2; chk("t2_araddr_inst", araddr, 32'hBFC00010);
    chk("t2_arid_inst", {28'd0, arid}, 0);
    tick(); arready = 0; rvalid = 1; rid = 0;
    #2; chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 1);
    tick(); rvalid = 0;

    // 3a: byte write, AW before W
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'hAA000000;
    #2; chk("t3a_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1;
    #2; chk("t3a_awvalid", {31'd0, awvalid}, 1);
    chk("t3a_wvalid", {31'd0, wvalid}, 1);
    chk("t3a_wstrb", {28'd0, wstrb}, 4'b1000);
    chk("t3a_awsize", {29'd0, awsize}, 0);
    chk("t3a_awaddr", awaddr, 32'h80000003);
    chk("t3a_awid", {28'd0, awid}, 1);
    chk("t3a_wdata", wdata, 32'hAA000000);
    chk("t3a_wlast", {31'd0, wlast}, 1);
    tick(); awready = 0; wready = 1;
    #2; chk("t3a_aw_dropped", {31'd0, awvalid}, 0);
    chk("t3a_w_held", {31'd0, wvalid}, 1);
    tick(); wready = 0;
    #2; chk("t3a_wvalid_low", {31'd0, wvalid}, 0);
    chk("t3a_bready", {31'd0, bready}, 1);
    chk("t3a_no_ok_yet", {31'd0, data_data_ok}, 0);
    bvalid = 1; bid = 1;
    #2; chk("t3a_data_ok", {31'd0, data_data_ok}, 1);
    tick(); bvalid = 0;
    #2; chk("t3a_bready_low", {31'd0, bready}, 0);

    // 3b: halfword write, W before AW
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h80000002; data_wdata = 32'hBEEF0000;
    #2; chk("t3b_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; wready = 1;
    #2; chk("t3b_wstrb", {28'd0, wstrb}, 4'b1100);
    chk("t3b_awsize", {29'd0, awsize}, 1);
    tick(); wready = 0; awready = 1;
    #2; chk("t3b_w_dropped", {31'd0, wvalid}, 0);
    chk("t3b_aw_held", {31'd0, awvalid}, 1);
    tick(); awready = 0;
    #2; chk("t3b_bready", {31'd0, bready}, 1);
    bvalid = 1;
    #2; chk("t3b_data_ok", {31'd0, data_data_ok}, 1);
    tick(); bvalid = 0;

    // 3c: word write, AW and W together
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010; data_wdata = 32'h01020304;
    #2; chk("t3c_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1; wready = 1;
    #2; chk("t3c_wstrb", {28'd0, wstrb}, 4'b1111);
    tick(); awready = 0; wready = 0;
    #2; chk("t3c_bready", {31'd0, bready}, 1);
    chk("t3c_valids_low", {30'd0, awvalid, wvalid}, 0);
    bvalid = 1;
    #2; chk("t3c_data_ok", {31'd0, data_data_ok}, 1);
    tick(); bvalid = 0;

    // 4: write pending in W_B; same-word data read held, other-word inst read proceeds
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'hCAFEF00D;
    #2; chk("t4_wr_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1; wready = 1;
    tick(); awready = 0; wready = 0;
    data_req = 1; data_wr = 0; data_addr = 32'h80001000;
    inst_req = 1; inst_addr = 32'h80001004;
    #2; chk("t4_data_rd_blocked", {31'd0, data_addr_ok}, 0);
    chk("t4_inst_rd_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    #2; chk("t4_inst_araddr", araddr, 32'h80001004);
    chk("t4_data_still_blocked", {31'd0, data_addr_ok}, 0);
    tick(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h11112222;
    #2; chk("t4_inst_data_ok", {31'd0, inst_data_ok}, 1);
    tick(); rvalid = 0; bvalid = 1;
    #2; chk("t4_write_done", {31'd0, data_data_ok}, 1);
    chk("t4_blocked_at_b", {31'd0, data_addr_ok}, 0);
    tick(); bvalid = 0;
    #2; chk("t4_data_rd_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; arready = 1;
    #2; chk("t4_data_araddr", araddr, 32'h80001000);
    chk("t4_data_arid", {28'd0, arid}, 1);
    tick(); arready = 0; rvalid = 1; rid = 1;
    #2; chk("t4_data_rd_done", {31'd0, data_data_ok}, 1);
    tick(); rvalid = 0;

    // 4b: inst read to the word of a pending write is held until B completes
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80002000;
    #2; chk("t4b_wr_addr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1; wready = 1;
    tick(); awready = 0; wready = 0; inst_req = 1; inst_addr = 32'h80002002;
    #2; chk("t4b_inst_raw_blocked", {31'd0, inst_addr_ok}, 0);
    bvalid = 1;
    tick(); bvalid = 0;
    #2; chk("t4b_inst_after_b", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    tick(); arready = 0; rvalid = 1; rid = 0;
    #2; chk("t4b_inst_data_ok", {31'd0, inst_data_ok}, 1);
    tick(); rvalid = 0;

    // 5: reset while waiting in R_R
    inst_req = 1; inst_addr = 32'h00001000;
    #2; chk("t5_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    tick(); arready = 0;
    #2; chk("t5_in_r", {31'd0, rready}, 1);
    rst = 1; inst_req = 1; rvalid = 1; rid = 0;
    #2; chk("t5_rst_addr_ok", {31'd0, inst_addr_ok}, 0);
    chk("t5_rst_data_ok", {31'd0, inst_data_ok}, 0);
    tick(); rvalid = 0;
    #2; chk("t5_arvalid_rready", {30'd0, arvalid, rready}, 0);
    chk("t5_held_in_rst", {31'd0, inst_addr_ok}, 0);
    rst = 0; inst_addr = 32'h00002000;
    #2; chk("t5_accept_after_rst", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; arready = 1;
    #2; chk("t5_araddr", araddr, 32'h00002000);
    tick(); arready = 0; rvalid = 1; rid = 0;
    #2; chk("t5_data_ok", {31'd0, inst_data_ok}, 1);
    tick(); rvalid = 0;

`ifdef SRAM_AXI_ERR_EN
    // 6: sticky bus error
    #2; chk("t6_err_init", {31'd0, bus_err}, 0);
    data_write(32'h80003000, 2'b10);
    #2; chk("t6_err_set", {31'd0, bus_err}, 1);
    data_write(32'h80003004, 2'b00);
    #2; chk("t6_err_sticky", {31'd0, bus_err}, 1);
    rst = 1;
    tick(); rst = 0;
    #2; chk("t6_err_cleared", {31'd0, bus_err}, 0);
`else
    data_write(32'h80003000, 2'b10);
    #2; chk("t6_idle_after_wr", {30'd0, awvalid, bready}, 0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
